program_bus_arbiter: RTL

- Shares the single program ROM port (program_addr_bus / program_data_bus) between the core's instruction-fetch port and a data-read port used for loads from the program region.
- Sits between rv32e_soc internals and program_rom.
- Arbitrates simultaneous requests, sequences each ROM access through a small FSM with configurable wait states, and returns registered read data with a one-cycle ready pulse.

---
 rtl/program_bus_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/program_bus_arbiter.sv
// program_bus_arbiter: shares one program ROM port between instruction fetch
// and data reads from the program region. Each access runs IDLE -> ADDR ->
// RESP. ADDR lasts WAIT_CYCLES+1 cycles. Read data is registered, and the
// winner's ready pulses for one cycle.
// Optional macro PROG_ARB_RR_EN: strict alternation between requesters when
// both ask at once. When the macro is undefined, data has priority, but fetch
// wins after MAX_DATA_BURST data grants in a row.
module program_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_CYCLES    = 0,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] program_addr_bus,
  input  logic [DATA_WIDTH-1:0] program_data_bus,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] frd_q, frd_d;
  logic [DATA_WIDTH-1:0] drd_q, drd_d;
  logic [3:0]            wait_q, wait_d;
  logic [3:0]            burst_q, burst_d;
  logic                  last_q, last_d;   // 1: last grant went to data
  logic                  win_q, win_d;     // 1: current access belongs to data
  logic                  pick_data;

  // Pick the requester that wins if a grant happens this cycle.
  always_comb begin
    pick_data = 1'b0;
`ifdef PROG_ARB_RR_EN
    pick_data = data_req && (!fetch_req || !last_q);
`else
    pick_data = data_req && !(fetch_req && (burst_q == 4'(MAX_DATA_BURST)));
`endif
  end

  // Compute the next FSM state, latch the address and capture read data.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    frd_d   = frd_q;
    drd_d   = drd_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    last_d  = last_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          win_d   = pick_data;
          last_d  = pick_data;
          addr_d  = pick_data ? data_addr : fetch_addr;
          wait_d  = 4'(WAIT_CYCLES);
          state_d = ADDR;
`ifndef PROG_ARB_RR_EN
          // Count data grants only while fetch is starved. Any other grant
          // clears the count.
          burst_d = (pick_data && fetch_req) ? burst_q + 4'd1 : 4'd0;
`endif
        end
      end
      ADDR: begin
        if (wait_q == 4'd0) begin
          if (win_q) drd_d = program_data_bus;
          else       frd_d = program_data_bus;
          state_d = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      frd_q   <= '0;
      drd_q   <= '0;
      wait_q  <= '0;
      burst_q <= '0;
      last_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      frd_q   <= frd_d;
      drd_q   <= drd_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign program_addr_bus = addr_q;
  assign fetch_rdata      = frd_q;
  assign data_rdata       = drd_q;
  assign fetch_ready      = (state_q == RESP) && !win_q;
  assign data_ready       = (state_q == RESP) && win_q;
  assign busy             = (state_q != IDLE);

endmodule
